mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32: address width of all ports.
REQ-002 Parameter DATA_W, default 32: data width of all ports.
REQ-003 Parameter MAX_D_STREAK, default 4: maximum consecutive data grants issued while a fetch is pending.
REQ-004 Parameter TIMEOUT_CYC, default 64: cycles in a bus state without m_ack before abort.
REQ-005 The block SHALL use one clock, clk, and reset rst, which SHALL be synchronous and active-high, as already decided.
REQ-006 Ports, one per entry: name, direction, width, meaning.
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- if_req  in  1  fetch request, held until if_ready.
- if_addr  in  ADDR_W  fetch address, stable while if_req.
- if_rdata  out  DATA_W  fetch data, valid with if_ready.
- if_ready  out  1  fetch complete, one-cycle pulse.
- d_req  in  1  data request, held until d_ready.
- d_we  in  1  1 = write, 0 = read.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_rdata  out  DATA_W  load data, valid with d_ready.
- d_ready  out  1  data complete, one-cycle pulse.
- m_req  out  1  memory request.
- m_we  out  1  memory write enable.
- m_addr  out  ADDR_W  memory address.
- m_wdata  out  DATA_W  memory write data.
- m_rdata  in  DATA_W  memory read data.
- m_ack  in  1  memory completion, one cycle.
- busy  out  1  state is not IDLE.
- err  out  1  sticky timeout flag.

Function
REQ-007 The FSM SHALL have three states: IDLE, BUS_IF and BUS_D.
REQ-008 In IDLE, the arbiter SHALL choose as follows.
- d_req alone selects BUS_D; if_req alone selects BUS_IF.
- Both high: BUS_D, unless streak == MAX_D_STREAK, then BUS_IF.
REQ-009 On entering a bus state, the block SHALL register the granted address, we and wdata.
- m_req, m_addr, m_we and m_wdata SHALL be driven from those registers.
- m_req SHALL be high for every cycle in BUS_IF or BUS_D.
- Minimum request-to-m_req latency SHALL be 1 cycle.
REQ-010 The ready outputs SHALL be combinational and pulse in the m_ack cycle.
- if_ready = m_ack & BUS_IF; d_ready = m_ack & BUS_D.
- if_rdata and d_rdata SHALL pass m_rdata through.
REQ-011 On m_ack, the FSM SHALL return to IDLE at the next edge; there SHALL be one idle bubble between transactions.
REQ-012 m_ack in IDLE SHALL be ignored and SHALL produce no ready pulse.
REQ-013 Streak counter, 0..MAX_D_STREAK, saturating, updated at IDLE grants only.
- Data grant with if_req high: increment.
- Fetch grant: clear.
- Any grant with if_req low: clear.
REQ-014 The watchdog SHALL count cycles in a bus state and clear on entering a bus state.
- At TIMEOUT_CYC cycles without m_ack, the granted ready SHALL pulse for one cycle.
- With that pulse, if_rdata SHALL be forced to 32'h0000_0013 (NOP) or d_rdata to 0.
- err SHALL set and the FSM SHALL go to IDLE.
REQ-015 m_ack in the same cycle as the timeout SHALL take precedence: normal completion, no err.
REQ-016 Write data transactions SHALL also pulse d_ready on m_ack; d_rdata is don't-care for writes.
REQ-017 Requester inputs changing while that requester is granted SHALL be ignored; the latched values SHALL be used.

Reset
REQ-018 Reset SHALL force the following.
- State IDLE; streak, watchdog and err cleared.
- m_req, m_we, if_ready, d_ready and busy = 0.
- m_addr and m_wdata = 0.
REQ-019 Reset during BUS_* SHALL abandon the transaction.
- m_req SHALL drop in the cycle after the reset edge, with no ready pulse.
- m_ack during rst high SHALL be ignored.

Structure
REQ-020 Package riscv_pkg SHALL hold the FSM state encoding and the NOP constant 32'h0000_0013.
REQ-021 The watchdog counter SHALL be sub-module mem_watchdog, with inputs clk, rst, start, active and ack, and output expire.

Verification
REQ-022 Single fetch: if_req at addr 0x10, m_ack after 3 cycles with 0x00A00093 -> m_req for 3 cycles, if_ready one pulse with if_rdata 0x00A00093, then IDLE.
REQ-023 Contention: if_req and d_req held continuously, each ack after 1 cycle -> grant order D,D,D,D,IF,D,D,D,D,IF.
REQ-024 Write: d_req, d_we=1, addr 0x100, wdata 0xDEADBEEF -> m_we=1, m_addr 0x100, m_wdata 0xDEADBEEF, d_ready on ack.
REQ-025 Timeout: fetch with no m_ack for 64 cycles -> if_ready pulse, if_rdata 0x00000013, err=1 until rst.
REQ-026 Reset mid-transaction: rst pulsed in BUS_D cycle 2, then m_ack -> m_req low, no d_ready, state IDLE, streak 0.
REQ-027 Stray ack: m_ack in IDLE -> no ready pulse, state unchanged.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared definitions for the memory arbiter.
//   arb_state_e : arbiter FSM state encoding (IDLE, BUS_IF, BUS_D)
//   NOP_INSN    : instruction returned on a fetch that times out
package riscv_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_BUS_IF = 2'd1,
    S_BUS_D  = 2'd2
  } arb_state_e;

  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

endpackage

// File: rtl/mem_watchdog.sv
// Bus-state watchdog for the memory arbiter.
//   clk, rst : clock, synchronous active-high reset
//   start    : a bus state is being entered at the next edge (clears the count)
//   active   : arbiter is currently in a bus state
//   ack      : memory completion this cycle
//   expire   : this is the TIMEOUT_CYC-th bus cycle without m_ack
module mem_watchdog #(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic active,
  input  logic ack,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // The count is 0 in the first bus cycle, so it reads TIMEOUT_CYC-1 in the
  // TIMEOUT_CYC-th cycle. It holds at LAST; the arbiter leaves the bus state
  // on expiry anyway.
  always_comb begin
    cnt_d = cnt_q;
    if (start) begin
      cnt_d = '0;
    end else if (active && !ack && (cnt_q != LAST)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // An ack in the expiry cycle wins, so expire is suppressed by ack.
  assign expire = active && !ack && (cnt_q == LAST);

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester (fetch / data) arbiter onto a single memory port.
//   clk, rst                      : clock, synchronous active-high reset
//   if_req/if_addr                : fetch request (held until if_ready)
//   if_rdata/if_ready             : fetch data and one-cycle completion pulse
//   d_req/d_we/d_addr/d_wdata     : data request (held until d_ready)
//   d_rdata/d_ready               : load data and one-cycle completion pulse
//   m_req/m_we/m_addr/m_wdata     : memory request, driven from latched grant
//   m_rdata/m_ack                 : memory read data and one-cycle completion
//   busy                          : FSM not in IDLE
//   err                           : sticky watchdog timeout flag
//   dbg_state, dbg_streak         : FSM state and data-streak count
// Handshake: a requester raises *_req with stable operands and holds it until
// its *_ready pulse; the request is latched at grant and later changes are
// ignored. Memory sees m_req high for the whole bus state; one m_ack cycle
// completes it, and the matching ready pulses combinationally in that cycle.
module mem_arbiter
  import riscv_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MAX_D_STREAK = 4,
  parameter int TIMEOUT_CYC  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_ack,
  output logic              busy,
  output logic              err,
  output logic [1:0]        dbg_state,
  output logic [7:0]        dbg_streak
);

  localparam int SW = $clog2(MAX_D_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

  arb_state_e        state_q, state_d;
  logic [SW-1:0]     streak_q, streak_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              err_q, err_d;
  logic              grant_start;
  logic              in_bus;
  logic              expire;

  assign in_bus = (state_q != S_IDLE);

  mem_watchdog #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .start  (grant_start),
    .active (in_bus),
    .ack    (m_ack),
    .expire (expire)
  );

  always_comb begin
    state_d     = state_q;
    streak_d    = streak_q;
    addr_d      = addr_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    err_d       = err_q;
    grant_start = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Data wins unless it has already taken MAX_D_STREAK grants in a row
        // while a fetch was waiting.
        if (d_req && (!if_req || (streak_q != STREAK_MAX))) begin
          state_d     = S_BUS_D;
          addr_d      = d_addr;
          we_d        = d_we;
          wdata_d     = d_wdata;
          grant_start = 1'b1;
          streak_d    = if_req ? (streak_q + SW'(1)) : '0;
        end else if (if_req) begin
          state_d     = S_BUS_IF;
          addr_d      = if_addr;
          we_d        = 1'b0;
          wdata_d     = '0;
          grant_start = 1'b1;
          streak_d    = '0;
        end
      end
      S_BUS_IF, S_BUS_D: begin
        if (m_ack) begin
          state_d = S_IDLE;
        end else if (expire) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      streak_q <= '0;
      addr_q   <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
      err_q    <= err_d;
    end
  end

  // Completion (ack or timeout) pulses the ready of the granted side; an ack
  // arriving while rst is asserted must not complete anything.
  always_comb begin
    if_ready = !rst && (state_q == S_BUS_IF) && (m_ack || expire);
    d_ready  = !rst && (state_q == S_BUS_D) && (m_ack || expire);
    if_rdata = expire ? DATA_W'(NOP_INSN) : m_rdata;
    d_rdata  = expire ? '0 : m_rdata;
  end

  assign m_req      = in_bus;
  assign m_we       = we_q;
  assign m_addr     = addr_q;
  assign m_wdata    = wdata_q;
  assign busy       = in_bus;
  assign err        = err_q;
  assign dbg_state  = state_q;
  assign dbg_streak = 8'(streak_q);

endmodule
